// File: rtl/run_dump_monitor.sv
// Purpose: end-of-run monitor; gates the machine, detects halt, streams regfile + memory window out.
// Latency: run_en drops the cycle after the halt edge; dump records are loaded one per cycle from the next edge on.
// Backpressure: single output slot held stable while dump_valid && !dump_ready; dump records never dropped.
//
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   pc, inst, inst_valid machine fetch observation
//   run_en              machine clock-enable (registered), 1 only in RUN
//   rf_raddr/rf_rdata   combinational register-file read port
//   mem_raddr/mem_rdata combinational data-memory read port (word index)
//   dump_*              valid/ready record stream {kind, index, data}
//   halt_cause          0 running, 1 zero instruction, 2 timeout
//   cycle_count         saturating RUN-cycle counter
//   trace_drop, done    sticky status flags
//
// Optional build macro RUN_DUMP_PC_TRACE_EN: emits a kind-0 PC trace record
// each valid RUN cycle through the same slot; records that find the slot
// busy are discarded and flagged on trace_drop.
module run_dump_monitor #(
    parameter int          NUM_REGS   = 32,
    parameter logic [31:0] MEM_BASE   = 32'h4000,
    parameter int          MEM_WORDS  = 4,
    parameter int          MAX_CYCLES = 640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    output logic        run_en,
    output logic [7:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [1:0]  dump_kind,
    output logic [15:0] dump_index,
    output logic [31:0] dump_data,
    output logic [1:0]  halt_cause,
    output logic [31:0] cycle_count,
    output logic        trace_drop,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DUMP_REG = 2'd1,
        ST_DUMP_MEM = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam logic [1:0]  KIND_PC    = 2'd0;
    localparam logic [1:0]  KIND_REG   = 2'd1;
    localparam logic [1:0]  KIND_MEM   = 2'd2;
    localparam logic [1:0]  HC_ZERO    = 2'd1;
    localparam logic [1:0]  HC_TIMEOUT = 2'd2;
    localparam logic [15:0] REG_LAST   = 16'(NUM_REGS - 1);
    localparam logic [15:0] MEM_LAST   = 16'(MEM_WORDS - 1);
    localparam logic [31:0] CYC_LAST   = 32'(MAX_CYCLES - 1);

    state_t      state;
    logic [15:0] idx;
    logic        slot_free;
    logic        xfer;
    logic        zero_inst;
    logic        timeout;

    // The slot may take a new record when empty or when its current record
    // leaves on this same edge.
    assign slot_free = !dump_valid || dump_ready;
    assign xfer      = dump_valid && dump_ready;
    assign zero_inst = inst_valid && (inst == 32'h0);
    assign timeout   = (cycle_count == CYC_LAST);

    always_comb begin
        rf_raddr  = 8'h0;
        mem_raddr = 32'h0;
        if (state == ST_DUMP_REG) begin
            rf_raddr = idx[7:0];
        end
        if (state == ST_DUMP_MEM) begin
            mem_raddr = MEM_BASE + {16'h0, idx};
        end
    end

`ifndef RUN_DUMP_PC_TRACE_EN
    // pc only feeds the trace record; keep it visibly consumed.
    logic unused_pc;
    assign unused_pc  = ^pc;
    assign trace_drop = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            idx         <= 16'h0;
            run_en      <= 1'b1;
            dump_valid  <= 1'b0;
            dump_kind   <= 2'd0;
            dump_index  <= 16'h0;
            dump_data   <= 32'h0;
            halt_cause  <= 2'd0;
            cycle_count <= 32'h0;
            done        <= 1'b0;
`ifdef RUN_DUMP_PC_TRACE_EN
            trace_drop  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    if (cycle_count != 32'hFFFF_FFFF) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
`ifdef RUN_DUMP_PC_TRACE_EN
                    if (inst_valid) begin
                        if (slot_free) begin
                            dump_valid <= 1'b1;
                            dump_kind  <= KIND_PC;
                            dump_index <= cycle_count[15:0];
                            dump_data  <= pc;
                        end else begin
                            trace_drop <= 1'b1;
                        end
                    end else if (xfer) begin
                        dump_valid <= 1'b0;
                    end
`endif
                    // Zero instruction wins when both conditions coincide.
                    if (zero_inst || timeout) begin
                        state      <= ST_DUMP_REG;
                        run_en     <= 1'b0;
                        idx        <= 16'h0;
                        halt_cause <= zero_inst ? HC_ZERO : HC_TIMEOUT;
                    end
                end

                ST_DUMP_REG: begin
                    // A pending trace record keeps slot_free low until it
                    // leaves, so register records cannot overtake it.
                    if (slot_free) begin
                        dump_valid <= 1'b1;
                        dump_kind  <= KIND_REG;
                        dump_index <= idx;
                        dump_data  <= rf_rdata;
                        if (idx == REG_LAST) begin
                            idx   <= 16'h0;
                            state <= (MEM_WORDS == 0) ? ST_DONE : ST_DUMP_MEM;
                        end else begin
                            idx <= idx + 16'd1;
                        end
                    end
                end

                ST_DUMP_MEM: begin
                    if (slot_free) begin
                        dump_valid <= 1'b1;
                        dump_kind  <= KIND_MEM;
                        dump_index <= idx;
                        dump_data  <= mem_rdata;
                        if (idx == MEM_LAST) begin
                            idx   <= 16'h0;
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + 16'd1;
                        end
                    end
                end

                ST_DONE: begin
                    // DONE is entered with the final record still in the slot.
                    if (xfer) begin
                        dump_valid <= 1'b0;
                        done       <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_dump_monitor.sv
module tb_run_dump_monitor;

`ifdef RUN_DUMP_PC_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h0;
    logic [31:0] inst = 32'h13;
    logic        inst_valid = 1'b0;
    logic        run_en;
    logic [7:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        dump_valid;
    logic        dump_ready = 1'b1;
    logic [1:0]  dump_kind;
    logic [15:0] dump_index;
    logic [31:0] dump_data;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count;
    logic        trace_drop;
    logic        done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Register file and memory models: data encodes the address read.
    assign rf_rdata  = 32'hA5A5_0000 | {24'h0, rf_raddr};
    assign mem_rdata = mem_raddr ^ 32'h5A5A_0000;

    run_dump_monitor #(.MAX_CYCLES(20)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .run_en      (run_en),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_kind   (dump_kind),
        .dump_index  (dump_index),
        .dump_data   (dump_data),
        .halt_cause  (halt_cause),
        .cycle_count (cycle_count),
        .trace_drop  (trace_drop),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " run_en"},      64'(run_en),      64'd1);
        chk({tag, " dump_valid"},  64'(dump_valid),  64'd0);
        chk({tag, " dump_kind"},   64'(dump_kind),   64'd0);
        chk({tag, " dump_index"},  64'(dump_index),  64'd0);
        chk({tag, " dump_data"},   64'(dump_data),   64'd0);
        chk({tag, " halt_cause"},  64'(halt_cause),  64'd0);
        chk({tag, " cycle_count"}, 64'(cycle_count), 64'd0);
        chk({tag, " trace_drop"},  64'(trace_drop),  64'd0);
        chk({tag, " done"},        64'(done),        64'd0);
        chk({tag, " rf_raddr"},    64'(rf_raddr),    64'd0);
        chk({tag, " mem_raddr"},   64'(mem_raddr),   64'd0);
    endtask

    // Assert reset at a negedge, release at a later negedge.
    task automatic do_reset();
        reset      = 1'b0;
        inst_valid = 1'b0;
        inst       = 32'h13;
        dump_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Execute non-zero instructions until cycle_count reaches target.
    task automatic wait_count(input logic [31:0] target, input string tag);
        int  n = 0;
        bit  seen_valid = 1'b0;
        while (cycle_count !== target && n < 2000) begin
            pc         = pc + 32'd4;
            inst       = 32'h0000_0013;
            inst_valid = 1'b1;
            @(negedge clk);
            if (dump_valid) seen_valid = 1'b1;
            n++;
        end
        chk({tag, " reach_count"}, 64'(cycle_count), 64'(target));
        if (!TRACE) chk({tag, " no_valid_in_run"}, 64'(seen_valid), 64'd0);
    endtask

    // Consume a full dump, checking order, payload, stall stability and done.
    task automatic run_dump(input bit bp, input string tag);
        int          seq = 0;
        int          cyc = 0;
        int          last_xfer = -10;
        bit          stalled = 1'b0;
        logic [49:0] held = '0;
        logic [49:0] cur;
        logic [49:0] exp;
        logic [3:0]  pat = 4'b1001;
        while (done !== 1'b1 && cyc < 2000) begin
            if (bp) begin
                if ($urandom_range(0, 3) == 0) dump_ready = 1'($urandom_range(0, 1));
                else                           dump_ready = pat[cyc % 4];
            end else begin
                dump_ready = 1'b1;
            end
            cur = {dump_kind, dump_index, dump_data};
            if (stalled) chk({tag, " stall_hold"}, 64'(cur), 64'(held));
            if (dump_valid && dump_ready && !(TRACE && dump_kind == 2'd0)) begin
                if (seq < 32) exp = {2'd1, 16'(seq), 32'hA5A5_0000 | 32'(seq)};
                else          exp = {2'd2, 16'(seq - 32), (32'h4000 + 32'(seq - 32)) ^ 32'h5A5A_0000};
                chk($sformatf("%s rec%0d", tag, seq), 64'(cur), 64'(exp));
                seq++;
                last_xfer = cyc;
            end
            stalled = dump_valid && !dump_ready;
            held    = cur;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done"},          64'(done),            64'd1);
        chk({tag, " record_count"},  64'(seq),             64'd36);
        chk({tag, " done_latency"},  64'(cyc - last_xfer), 64'd1);
        chk({tag, " valid_low"},     64'(dump_valid),      64'd0);
        dump_ready = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 reset = 1'b0;
        #1 chk_reset("por");
        @(negedge clk);
        reset = 1'b1;

        // Zero-instruction halt at RUN cycle 10
        wait_count(32'd10, "zero");
        chk("zero pre run_en", 64'(run_en), 64'd1);
        chk("zero pre halt",   64'(halt_cause), 64'd0);
        pc = pc + 32'd4; inst = 32'h0; inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0; inst = 32'h13;
        chk("zero run_en",     64'(run_en), 64'd0);
        chk("zero halt_cause", 64'(halt_cause), 64'd1);
        chk("zero count",      64'(cycle_count), 64'd11);
        run_dump(1'b0, "zero");
        repeat (3) @(negedge clk);
        chk("zero count_hold", 64'(cycle_count), 64'd11);
        chk("zero halt_hold",  64'(halt_cause), 64'd1);
        chk("zero done_hold",  64'(done), 64'd1);
        chk("zero trace_drop", 64'(trace_drop), 64'd0);

        // Timeout with backpressure on the dump
        do_reset();
        chk("to reset count", 64'(cycle_count), 64'd0);
        chk("to reset done",  64'(done), 64'd0);
        wait_count(32'd19, "to");
        chk("to pre run_en", 64'(run_en), 64'd1);
        chk("to pre halt",   64'(halt_cause), 64'd0);
        @(negedge clk);
        inst_valid = 1'b0;
        chk("to halt_cause", 64'(halt_cause), 64'd2);
        chk("to count",      64'(cycle_count), 64'd20);
        chk("to run_en",     64'(run_en), 64'd0);
        run_dump(1'b1, "bp");
        chk("to count_hold", 64'(cycle_count), 64'd20);
        chk("to halt_hold",  64'(halt_cause), 64'd2);

        // Zero instruction on the timeout edge, then reset mid-dump
        do_reset();
        wait_count(32'd19, "sim");
        pc = pc + 32'd4; inst = 32'h0; inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0; inst = 32'h13;
        chk("sim halt_cause", 64'(halt_cause), 64'd1);
        chk("sim count",      64'(cycle_count), 64'd20);
        begin
            int n = 0;
            dump_ready = 1'b1;
            while (!(dump_valid && dump_kind == 2'd1 && dump_index == 16'd5) && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("mid reached_rec5", 64'(dump_index), 64'd5);
        end
        #2 reset = 1'b0;
        #1 chk_reset("mid");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_count(32'd3, "again");
        pc = pc + 32'd4; inst = 32'h0; inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0; inst = 32'h13;
        chk("again halt_cause", 64'(halt_cause), 64'd1);
        chk("again count",      64'(cycle_count), 64'd4);
        run_dump(1'b0, "again");

        // Stalled consumer during RUN; three RUN cycles including the halt
        do_reset();
        dump_ready = 1'b0;
        pc = 32'h100; inst = 32'h13; inst_valid = 1'b1;
        @(negedge clk);
        if (TRACE) begin
            chk("tr first rec", 64'({dump_valid, dump_kind, dump_index, dump_data}),
                64'({1'b1, 2'd0, 16'd0, 32'h100}));
            chk("tr drop0", 64'(trace_drop), 64'd0);
        end else begin
            chk("nt valid0", 64'(dump_valid), 64'd0);
        end
        pc = 32'h104;
        @(negedge clk);
        chk("tr drop1", 64'(trace_drop), TRACE ? 64'd1 : 64'd0);
        if (TRACE) chk("tr hold1", 64'({dump_valid, dump_kind, dump_index, dump_data}),
                       64'({1'b1, 2'd0, 16'd0, 32'h100}));
        else       chk("nt valid1", 64'(dump_valid), 64'd0);
        pc = 32'h108; inst = 32'h0;
        @(negedge clk);
        inst_valid = 1'b0; inst = 32'h13;
        chk("tr halt_cause", 64'(halt_cause), 64'd1);
        chk("tr run_en",     64'(run_en), 64'd0);
        @(negedge clk);
        if (TRACE) begin
            chk("tr hold_in_dump", 64'({dump_valid, dump_kind, dump_index, dump_data}),
                64'({1'b1, 2'd0, 16'd0, 32'h100}));
            dump_ready = 1'b1;
            @(negedge clk);
            chk("tr reg0_after", 64'({dump_valid, dump_kind, dump_index, dump_data}),
                64'({1'b1, 2'd1, 16'd0, 32'hA5A5_0000}));
        end else begin
            chk("nt reg0_blocked", 64'({dump_valid, dump_kind, dump_index, dump_data}),
                64'({1'b1, 2'd1, 16'd0, 32'hA5A5_0000}));
        end
        run_dump(1'b0, "tr");
        chk("tr drop_final", 64'(trace_drop), TRACE ? 64'd1 : 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_dump_monitor.md
# run_dump_monitor

Synthesizable end-of-run monitor that sits beside the `machine` datapath and replaces the fixed simulation-only halt/dump bench logic. It gates machine execution, detects halt on an all-zero instruction or on a cycle-limit timeout, then streams the register file and a configurable data-memory window out through a valid/ready record port. Register count, memory window and cycle limit are parameters, and an optional per-cycle PC trace shares the same port.

## Interface
- `NUM_REGS`, 32: register-file entries dumped, 1..256.
- `MEM_BASE`, 32'h4000: first data-memory word index dumped.
- `MEM_WORDS`, 4: memory words dumped, 0..65535; 0 skips the memory phase.
- `MAX_CYCLES`, 640: RUN cycles before timeout, ≥ 2.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = in reset.
- `pc`  in  32  machine byte PC.
- `inst`  in  32  current instruction.
- `inst_valid`  in  1  `inst`/`pc` meaningful this cycle.
- `run_en`  out  1  machine clock-enable; 1 only in RUN.
- `rf_raddr`  out  8  register-file read index, combinational read.
- `rf_rdata`  in  32  register data for `rf_raddr`, same cycle.
- `mem_raddr`  out  32  data-memory word index, combinational read.
- `mem_rdata`  in  32  memory data for `mem_raddr`, same cycle.
- `dump_valid`  out  1  record present.
- `dump_ready`  in  1  consumer accepts record.
- `dump_kind`  out  2  0 = PC trace, 1 = register, 2 = memory.
- `dump_index`  out  16  register index, memory offset (0-based), or low 16 bits of the cycle count for PC records.
- `dump_data`  out  32  record payload.
- `halt_cause`  out  2  0 = running, 1 = zero instruction, 2 = timeout.
- `cycle_count`  out  32  RUN cycles elapsed; saturates at all-ones.
- `trace_drop`  out  1  sticky: a PC record was discarded.
- `done`  out  1  sticky: dump complete.

## Operation
- States: RUN → DUMP_REG → DUMP_MEM → DONE. With MEM_WORDS = 0, DUMP_REG goes straight to DONE.
- RUN:
  - `run_en` = 1 and `cycle_count` increments every cycle.
  - Zero-instruction halt: sampled `inst_valid && inst == 0`.
  - Timeout: `cycle_count == MAX_CYCLES-1` at the edge.
  - If both halt conditions hold on the same edge, `halt_cause` = 1; zero-instruction has priority.
  - On halt: next state DUMP_REG, `halt_cause` latched, index counter cleared.
- Output slot: a single register, loaded only when `!dump_valid || dump_ready`. A record is transferred on any edge with `dump_valid && dump_ready`.
- DUMP_REG:
  - `rf_raddr` = index.
  - When the slot is loadable, it captures {kind 1, index, `rf_rdata`} and the index increments.
  - After index NUM_REGS-1 is loaded, the index clears and the state advances.
  - While the slot is blocked, the index and `rf_raddr` hold.
- DUMP_MEM:
  - `mem_raddr` = MEM_BASE + index, 32-bit wrap.
  - Loads kind 2 records the same way as DUMP_REG, through index MEM_WORDS-1.
- DONE:
  - `done` = 1 is set when the final record transfers; the state is entered on the last load.
  - `dump_valid` falls after the final handshake.
  - Remains in DONE until reset; `halt_cause` and `cycle_count` hold.
- Outside the dump phases, `rf_raddr` and `mem_raddr` drive 0.

## Timing
- Reset values:
  - `run_en` = 1; state RUN.
  - `dump_valid`, `dump_kind`, `dump_index`, `dump_data` = 0.
  - `halt_cause` = 0, `cycle_count` = 0, `trace_drop` = 0, `done` = 0.
- `run_en` is registered. It reads 0 starting the cycle after the halt edge, so the machine executes nothing after the halting cycle.
- With `dump_ready` tied high, the first register record is valid the cycle after the halt edge. Records then arrive one per cycle, NUM_REGS + MEM_WORDS in total, and `done` rises the cycle after the last handshake.
- Backpressure: `dump_kind`, `dump_index` and `dump_data` stay stable while `dump_valid && !dump_ready`. No record is lost or duplicated in dump phases.
- Reset asserted mid-dump aborts immediately to the reset values. The next run starts from RUN with `cycle_count` = 0.

## Configuration
- Macro `RUN_DUMP_PC_TRACE_EN`.
- Defined:
  - Each RUN cycle with `inst_valid` offers {kind 0, `cycle_count[15:0]`, `pc`} to the slot.
  - If the slot is blocked, that record is dropped and `trace_drop` is set.
  - Dump records are never dropped. A pending trace record must transfer before the first register record loads.
- Undefined:
  - No kind 0 records are produced, and `dump_valid` = 0 throughout RUN.
  - `trace_drop` is tied to 0.

## Test plan
- Zero-instruction halt: defaults, `dump_ready` = 1, `inst` = 0 with `inst_valid` at RUN cycle 10. Expect `halt_cause` = 1, `run_en` = 0 from cycle 11, 32 register records with index 0..31 carrying `rf_rdata`, then 4 memory records with `mem_raddr` 0x4000..0x4003, then `done`.
- Timeout: MAX_CYCLES = 20, never a zero instruction. Expect the halt edge at `cycle_count` 19, `halt_cause` = 2, `cycle_count` frozen at 20.
- Simultaneous conditions: zero instruction on the same edge as the timeout. Expect `halt_cause` = 1.
- Backpressure: toggle `dump_ready` 1-0-0-1 pseudo-randomly. Expect exactly 36 transfers, in order, payload stable while stalled, `done` after the last transfer.
- Reset mid-dump: assert `reset` = 0 during register record 5. Expect all outputs at reset values immediately; after release, a full 36-record dump occurs on the next halt.
- Trace (`RUN_DUMP_PC_TRACE_EN` defined): `dump_ready` = 0 for 3 RUN cycles. Expect `trace_drop` = 1, the first trace record held unchanged, and register records beginning only after it transfers.
